// File: rtl/systolic_nbody_pkg.sv
// Shared types and schedule tables for the 2x2 systolic 4-body step scheduler.
package systolic_nbody_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_INTEG_REQ,
        ST_INTEG_WAIT,
        ST_DONE
    } state_t;

    localparam int NUM_BODIES  = 4;
    localparam int FEED_PHASES = 6;
    localparam int NUM_LANES   = 4;

    // Lane order is (Q0i, Q0j, Q1i, Q1j); value k selects body k, 0 drives the lane to zero.
    typedef logic [2:0] body_sel_t;

    localparam body_sel_t LANE_SEL [FEED_PHASES][NUM_LANES] = '{
        '{3'd1, 3'd1, 3'd0, 3'd0},
        '{3'd1, 3'd3, 3'd2, 3'd2},
        '{3'd3, 3'd3, 3'd2, 3'd4},
        '{3'd0, 3'd0, 3'd4, 3'd4},
        '{3'd0, 3'd0, 3'd0, 3'd0},
        '{3'd0, 3'd0, 3'd0, 3'd0}
    };

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_OPR0,
        SRC_OPR1,
        SRC_OPD0,
        SRC_OPD1
    } acc_src_t;

    // Array output feeding each body accumulator in each phase (diagonal trick).
    localparam acc_src_t ACC_SRC [FEED_PHASES][NUM_BODIES] = '{
        '{SRC_NONE, SRC_NONE, SRC_NONE, SRC_NONE},
        '{SRC_NONE, SRC_NONE, SRC_NONE, SRC_NONE},
        '{SRC_OPR0, SRC_NONE, SRC_NONE, SRC_NONE},
        '{SRC_OPR0, SRC_OPR1, SRC_OPD0, SRC_NONE},
        '{SRC_NONE, SRC_OPR1, SRC_OPR0, SRC_OPD1},
        '{SRC_NONE, SRC_NONE, SRC_NONE, SRC_OPR1}
    };

endpackage

// File: rtl/systolic_2x2_accum.sv
// Per-body acceleration accumulators fed from the array outputs by feed phase.
module systolic_2x2_accum
    import systolic_nbody_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 34
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr_i,
    input  logic                              en_i,
    input  logic [2:0]                        phase_i,
    input  logic [DW-1:0]                     opr_0_i,
    input  logic [DW-1:0]                     opr_1_i,
    input  logic [DW-1:0]                     opd_0_i,
    input  logic [DW-1:0]                     opd_1_i,
    output logic [NUM_BODIES-1:0][AW-1:0]     acc_o
);

    logic signed [AW-1:0] acc_q [NUM_BODIES];
    logic signed [AW-1:0] acc_d [NUM_BODIES];

    function automatic logic signed [AW-1:0] sext(input logic [DW-1:0] v);
        return {{(AW-DW){v[DW-1]}}, v};
    endfunction

    always_comb begin
        acc_src_t             src;
        logic signed [AW-1:0] add;
        for (int b = 0; b < NUM_BODIES; b++) begin
            src = SRC_NONE;
            add = '0;
            if (en_i && (phase_i < 3'(FEED_PHASES))) begin
                src = ACC_SRC[phase_i][b];
            end
            case (src)
                SRC_OPR0: add = sext(opr_0_i);
                SRC_OPR1: add = sext(opr_1_i);
                SRC_OPD0: add = sext(opd_0_i);
                SRC_OPD1: add = sext(opd_1_i);
                default:  add = '0;
            endcase
            acc_d[b] = clr_i ? '0 : acc_q[b] + add;
            acc_o[b] = acc_q[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BODIES; b++) acc_q[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BODIES; b++) acc_q[b] <= acc_d[b];
        end
    end

endmodule

// File: rtl/systolic_2x2_step_scheduler.sv
// Time-step sequencer: feeds body state through the 2x2 array, accumulates
// accelerations, and hands each body to the Verlet integrator per step.
module systolic_2x2_step_scheduler
    import systolic_nbody_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 34,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [1:0]    load_idx,
    input  logic [DW-1:0] load_q,
    input  logic [DW-1:0] load_m,
    input  logic          start,
    input  logic [SW-1:0] num_steps,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] step_count,
    output logic [DW-1:0] q_0i,
    output logic [DW-1:0] q_0j,
    output logic [DW-1:0] q_1i,
    output logic [DW-1:0] q_1j,
    output logic [DW-1:0] m_0i,
    output logic [DW-1:0] m_0j,
    output logic [DW-1:0] m_1i,
    output logic [DW-1:0] m_1j,
    input  logic [DW-1:0] opr_0,
    input  logic [DW-1:0] opr_1,
    input  logic [DW-1:0] opd_0,
    input  logic [DW-1:0] opd_1,
    output logic          integ_valid,
    input  logic          integ_ready,
    output logic [1:0]    integ_idx,
    output logic [DW-1:0] integ_q_t,
    output logic [DW-1:0] integ_q_told,
    output logic [AW-1:0] integ_a,
    input  logic          integ_rvalid,
    input  logic [DW-1:0] integ_q_new
);

    state_t        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [1:0]    k_q, k_d;
    logic [SW-1:0] step_q, step_d;
    logic [SW-1:0] nsteps_q, nsteps_d;
    logic          acc_clr;
    logic          load_we;
    logic          integ_we;

    logic signed [DW-1:0] q_q    [NUM_BODIES];
    logic signed [DW-1:0] qold_q [NUM_BODIES];
    logic signed [DW-1:0] m_q    [NUM_BODIES];

    logic [NUM_BODIES-1:0][AW-1:0] acc;
    logic [DW-1:0]                 lane_q [NUM_LANES];
    logic [DW-1:0]                 lane_m [NUM_LANES];

    systolic_2x2_accum #(.DW(DW), .AW(AW)) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (acc_clr),
        .en_i    (state_q == ST_FEED),
        .phase_i (phase_q),
        .opr_0_i (opr_0),
        .opr_1_i (opr_1),
        .opd_0_i (opd_0),
        .opd_1_i (opd_1),
        .acc_o   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            k_q      <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            k_q      <= k_d;
            step_q   <= step_d;
            nsteps_q <= nsteps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        k_d      = k_q;
        step_d   = step_q;
        nsteps_d = nsteps_q;
        acc_clr  = 1'b0;
        load_we  = 1'b0;
        integ_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_we = load_en;
                if (start) begin
                    nsteps_d = num_steps;
                    step_d   = '0;
                    if (num_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        acc_clr = 1'b1;
                        phase_d = '0;
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                if (phase_q == 3'(FEED_PHASES - 1)) begin
                    k_d     = '0;
                    state_d = ST_INTEG_REQ;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            ST_INTEG_REQ: begin
                if (integ_ready) state_d = ST_INTEG_WAIT;
            end
            ST_INTEG_WAIT: begin
                if (integ_rvalid) begin
                    integ_we = 1'b1;
                    if (k_q != 2'(NUM_BODIES - 1)) begin
                        k_d     = k_q + 2'd1;
                        state_d = ST_INTEG_REQ;
                    end else begin
                        step_d = step_q + SW'(1);
                        if (step_q + SW'(1) == nsteps_q) begin
                            state_d = ST_DONE;
                        end else begin
                            acc_clr = 1'b1;
                            phase_d = '0;
                            state_d = ST_FEED;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BODIES; b++) begin
                q_q[b]    <= '0;
                qold_q[b] <= '0;
                m_q[b]    <= '0;
            end
        end else if (load_we) begin
            q_q[load_idx]    <= load_q;
            qold_q[load_idx] <= load_q;
            m_q[load_idx]    <= load_m;
        end else if (integ_we) begin
            qold_q[k_q] <= q_q[k_q];
            q_q[k_q]    <= integ_q_new;
        end
    end

    always_comb begin
        body_sel_t sel;
        for (int l = 0; l < NUM_LANES; l++) begin
            sel       = '0;
            lane_q[l] = '0;
            lane_m[l] = '0;
            if ((state_q == ST_FEED) && (phase_q < 3'(FEED_PHASES))) begin
                sel = LANE_SEL[phase_q][l];
            end
            if (sel != '0) begin
                lane_q[l] = q_q[2'(sel - 3'd1)];
                lane_m[l] = m_q[2'(sel - 3'd1)];
            end
        end
    end

    assign q_0i = lane_q[0];
    assign q_0j = lane_q[1];
    assign q_1i = lane_q[2];
    assign q_1j = lane_q[3];
    assign m_0i = lane_m[0];
    assign m_0j = lane_m[1];
    assign m_1i = lane_m[2];
    assign m_1j = lane_m[3];

    // Request fields come straight from registers that only move on rvalid, so they stay put while waiting for ready.
    assign integ_valid  = (state_q == ST_INTEG_REQ);
    assign integ_idx    = integ_valid ? k_q         : '0;
    assign integ_q_t    = integ_valid ? q_q[k_q]    : '0;
    assign integ_q_told = integ_valid ? qold_q[k_q] : '0;
    assign integ_a      = integ_valid ? acc[k_q]    : '0;

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign step_count = step_q;

endmodule

// File: tb/tb_systolic_2x2_step_scheduler.sv
// Bench for systolic_2x2_step_scheduler: run-level body model plus literal pins.
module tb_systolic_2x2_step_scheduler;

    logic               clk;
    logic               rst_n;
    logic               load_en;
    logic [1:0]         load_idx;
    logic signed [31:0] load_q, load_m;
    logic               start;
    logic [15:0]        num_steps;
    logic               busy, done;
    logic [15:0]        step_count;
    logic signed [31:0] q_0i, q_0j, q_1i, q_1j, m_0i, m_0j, m_1i, m_1j;
    logic signed [31:0] opr_0, opr_1, opd_0, opd_1;
    logic               integ_valid, integ_ready, integ_rvalid;
    logic [1:0]         integ_idx;
    logic signed [31:0] integ_q_t, integ_q_told, integ_q_new;
    logic signed [33:0] integ_a;

    systolic_2x2_step_scheduler dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx),
        .load_q(load_q), .load_m(load_m), .start(start), .num_steps(num_steps),
        .busy(busy), .done(done), .step_count(step_count),
        .q_0i(q_0i), .q_0j(q_0j), .q_1i(q_1i), .q_1j(q_1j),
        .m_0i(m_0i), .m_0j(m_0j), .m_1i(m_1i), .m_1j(m_1j),
        .opr_0(opr_0), .opr_1(opr_1), .opd_0(opd_0), .opd_1(opd_1),
        .integ_valid(integ_valid), .integ_ready(integ_ready), .integ_idx(integ_idx),
        .integ_q_t(integ_q_t), .integ_q_told(integ_q_told), .integ_a(integ_a),
        .integ_rvalid(integ_rvalid), .integ_q_new(integ_q_new)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Array stub: constant outputs, or a cycle-varying pattern when vary=1.
    bit vary = 0;
    int vcnt = 0;
    always @(posedge clk) begin
        #1;
        vcnt++;
        if (vary) begin
            opr_0 = vcnt * 3 - 40;
            opr_1 = 1000 - vcnt * 7;
            opd_0 = -vcnt * 11;
            opd_1 = vcnt * 13 + 5;
        end else begin
            opr_0 = 3; opr_1 = 5; opd_0 = 7; opd_1 = 11;
        end
    end

    // Integrator stub: ready 3 cycles after valid, rvalid 2 cycles after accept, q_new = q + 1.
    int rdy_cnt = 0;
    int rv_cnt = -1;
    logic signed [31:0] qn_hold;
    initial begin
        integ_ready = 0; integ_rvalid = 0; integ_q_new = 0;
        forever begin
            @(posedge clk); #1;
            integ_rvalid = 0;
            if (!rst_n) begin
                integ_ready = 0; rdy_cnt = 0; rv_cnt = -1;
            end else if (integ_ready) begin
                integ_ready = 0;
                rv_cnt = 2;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    integ_rvalid = 1;
                    integ_q_new = qn_hold;
                    rv_cnt = -1;
                end
            end else if (integ_valid) begin
                rdy_cnt++;
                if (rdy_cnt >= 3) begin
                    integ_ready = 1;
                    qn_hold = integ_q_t + 1;
                    rdy_cnt = 0;
                end
            end
        end
    end

    // Run-level model of the bodies and of where the run is in its step.
    int lane_tab [4][4] = '{'{1,1,0,0}, '{1,3,2,2}, '{3,3,2,4}, '{0,0,4,4}};
    logic signed [31:0] mq [4], mqold [4], mm [4];
    logic signed [33:0] m_acc [4];
    bit  m_run, m_done, m_wait;
    int  m_ph, m_k, m_step, m_nsteps;
    longint cap_p2 [4], cap_qt [4], cap_qtold [4], cap_a [4];

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            mq[b] = 0; mqold[b] = 0; mm[b] = 0; m_acc[b] = 0;
        end
        m_run = 0; m_done = 0; m_wait = 0; m_ph = -1; m_k = -1; m_step = 0; m_nsteps = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        longint dq [4];
        longint dm [4];
        int sel;
        if (!rst_n) model_reset();
        dq[0] = q_0i; dq[1] = q_0j; dq[2] = q_1i; dq[3] = q_1j;
        dm[0] = m_0i; dm[1] = m_0j; dm[2] = m_1i; dm[3] = m_1j;
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("step_count", step_count, m_step);
        for (int l = 0; l < 4; l++) begin
            sel = (m_ph >= 0 && m_ph <= 3) ? lane_tab[m_ph][l] : 0;
            chk($sformatf("lane_q%0d_p%0d", l, m_ph), dq[l], sel != 0 ? mq[sel-1] : 0);
            chk($sformatf("lane_m%0d_p%0d", l, m_ph), dm[l], sel != 0 ? mm[sel-1] : 0);
            if (m_ph == 2) cap_p2[l] = dq[l];
        end
        chk("integ_valid", integ_valid, (m_k >= 0 && !m_wait));
        if (m_k >= 0 && !m_wait) begin
            chk("integ_idx", integ_idx, m_k);
            chk("integ_q_t", integ_q_t, mq[m_k]);
            chk("integ_q_told", integ_q_told, mqold[m_k]);
            chk("integ_a", integ_a, m_acc[m_k]);
            if (integ_ready) begin
                cap_qt[integ_idx] = integ_q_t;
                cap_qtold[integ_idx] = integ_q_told;
                cap_a[integ_idx] = integ_a;
            end
        end
        if (done) n_done++;
        if (rst_n) begin
            if (!m_run) begin
                if (load_en) begin
                    mq[load_idx] = load_q; mqold[load_idx] = load_q; mm[load_idx] = load_m;
                end
                if (start) begin
                    m_nsteps = num_steps; m_step = 0; m_run = 1;
                    if (num_steps == 0) m_done = 1;
                    else begin
                        m_ph = 0;
                        for (int b = 0; b < 4; b++) m_acc[b] = 0;
                    end
                end
            end else if (m_done) begin
                m_done = 0; m_run = 0;
            end else if (m_ph >= 0) begin
                case (m_ph)
                    2: m_acc[0] += opr_0;
                    3: begin m_acc[0] += opr_0; m_acc[1] += opr_1; m_acc[2] += opd_0; end
                    4: begin m_acc[1] += opr_1; m_acc[2] += opr_0; m_acc[3] += opd_1; end
                    5: m_acc[3] += opr_1;
                    default: ;
                endcase
                if (m_ph == 5) begin m_ph = -1; m_k = 0; m_wait = 0; end
                else m_ph++;
            end else if (m_k >= 0 && !m_wait) begin
                if (integ_ready) m_wait = 1;
            end else if (m_wait && integ_rvalid) begin
                mqold[m_k] = mq[m_k];
                mq[m_k] = integ_q_new;
                m_wait = 0;
                if (m_k < 3) m_k++;
                else begin
                    m_k = -1; m_step++;
                    if (m_step == m_nsteps) m_done = 1;
                    else begin
                        m_ph = 0;
                        for (int b = 0; b < 4; b++) m_acc[b] = 0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_load(input int idx, input int qv, input int mv);
        load_en = 1; load_idx = 2'(idx); load_q = qv; load_m = mv;
        cyc();
        load_en = 0;
    endtask

    task automatic clear_caps();
        for (int b = 0; b < 4; b++) begin
            cap_p2[b] = 999; cap_qt[b] = 999; cap_qtold[b] = 999; cap_a[b] = 999;
        end
    endtask

    task automatic do_start(input int n);
        clear_caps();
        start = 1; num_steps = 16'(n);
        cyc();
        start = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin cyc(); n++; end
        n_chk++;
        if (busy) begin
            n_fail++;
            $display("FAIL run_timeout: busy=%0d after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic load_base(input int m0, input int m1, input int m2, input int m3);
        do_load(0, -2, m0); do_load(1, -1, m1); do_load(2, 1, m2); do_load(3, 2, m3);
    endtask

    int d0;
    int wn;

    initial begin
        rst_n = 1; load_en = 0; load_idx = 0; load_q = 0; load_m = 0;
        start = 0; num_steps = 0;
        opr_0 = 3; opr_1 = 5; opd_0 = 7; opd_1 = 11;
        #2 rst_n = 0;
        repeat (4) cyc();
        chk("reset_busy", busy, 0);
        chk("reset_q0i", q_0i, 0);
        rst_n = 1;
        cyc();

        // num_steps = 0: straight to a done pulse
        do_start(0);
        chk("zero_done", done, 1);
        chk("zero_step", step_count, 0);
        cyc();
        chk("zero_done_clr", done, 0);
        chk("zero_idle", busy, 0);

        // Single step, constant array outputs
        load_base(1, 1, 1, 1);
        do_start(1);
        wait_idle(500);
        chk("p2_q0i", cap_p2[0], 1);
        chk("p2_q0j", cap_p2[1], 1);
        chk("p2_q1i", cap_p2[2], -1);
        chk("p2_q1j", cap_p2[3], 2);
        chk("a_b0", cap_a[0], 6);
        chk("a_b1", cap_a[1], 10);
        chk("a_b2", cap_a[2], 10);
        chk("a_b3", cap_a[3], 16);
        chk("qt_b0", cap_qt[0], -2);
        chk("qt_b3", cap_qt[3], 2);
        chk("step1", step_count, 1);

        // Post-step state seen through the next run's requests
        vary = 1;
        do_start(1);
        wait_idle(500);
        chk("s1_qt_b0", cap_qt[0], -1);
        chk("s1_qt_b1", cap_qt[1], 0);
        chk("s1_qt_b2", cap_qt[2], 2);
        chk("s1_qt_b3", cap_qt[3], 3);
        chk("s1_qold_b0", cap_qtold[0], -2);
        chk("s1_qold_b3", cap_qtold[3], 2);

        // Multi-step run
        load_base(10, 20, 30, 40);
        d0 = n_done;
        do_start(3);
        wait_idle(1000);
        chk("multi_step", step_count, 3);
        chk("multi_done_pulses", n_done - d0, 1);
        do_start(1);
        wait_idle(500);
        chk("m3_qt_b0", cap_qt[0], 1);
        chk("m3_qt_b1", cap_qt[1], 2);
        chk("m3_qt_b2", cap_qt[2], 4);
        chk("m3_qt_b3", cap_qt[3], 5);
        chk("m3_qold_b1", cap_qtold[1], 1);

        // Reset during integration wait of step 2
        load_base(1, 2, 3, 4);
        do_start(3);
        wn = 0;
        while (!(m_step == 1 && m_wait) && wn < 500) begin cyc(); wn++; end
        chk("reached_wait_s2", (m_step == 1 && m_wait), 1);
        rst_n = 0;
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_step", step_count, 0);
        rst_n = 1;
        cyc();
        do_start(1);
        wait_idle(500);
        chk("post_rst_qt_b0", cap_qt[0], 0);
        chk("post_rst_qt_b3", cap_qt[3], 0);
        chk("post_rst_step", step_count, 1);

        // Load and start in the same cycle
        clear_caps();
        load_en = 1; load_idx = 0; load_q = 5; load_m = 2;
        start = 1; num_steps = 1;
        cyc();
        load_en = 0; start = 0;
        wait_idle(500);
        chk("ls_qt_b0", cap_qt[0], 5);
        chk("ls_qt_b1", cap_qt[1], 1);

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_2x2_step_scheduler.md
Name: systolic_2x2_step_scheduler

Overview:
- Time-step sequencer for the 2x2 systolic force array, 4-body configuration.
- Holds body state (q, q_old, m) for 4 bodies and drives the 4 operand lanes in a fixed 6-cycle block schedule.
- Accumulates array partial outputs into per-body accelerations using the diagonal trick.
- Hands each body to the Verlet integration unit over a valid/ready handshake, then repeats for num_steps.

Parameters:
- DW, 32, signed fixed-point width of q, m and array outputs.
- AW, 34, accumulator width. Wraps two's complement, no saturation.
- SW, 16, step-counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  write body state, accepted only in IDLE
- load_idx  in  2  body index 0..3 (body k+1)
- load_q  in  DW  position; written to both q and q_old
- load_m  in  DW  mass
- start  in  1  begin run, sampled in IDLE only
- num_steps  in  SW  number of timesteps, latched on start
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of run
- step_count  out  SW  completed timesteps in current run
- q_0i, q_0j, q_1i, q_1j  out  DW  array position lanes
- m_0i, m_0j, m_1i, m_1j  out  DW  array mass lanes
- opr_0, opr_1, opd_0, opd_1  in  DW  array right/down outputs. Array pd/pr inputs are tied to 0 at top level.
- integ_valid  out  1  integration request
- integ_ready  in  1  integrator accepts request
- integ_idx  out  2  body index of request
- integ_q_t, integ_q_told  out  DW  current and previous position
- integ_a  out  AW  accumulated acceleration. G·dt² scaling is applied in the integrator.
- integ_rvalid  in  1  result strobe, arrives at least one cycle after acceptance
- integ_q_new  in  DW  updated position

Behaviour:
- Reset: all outputs 0, FSM in IDLE, q/q_old/m/acc registers 0, step_count 0.
- FSM states: IDLE, FEED, INTEG_REQ, INTEG_WAIT, DONE.
- IDLE:
  - load_en writes q[idx], q_old[idx], m[idx].
  - start latches num_steps and clears step_count.
  - start with num_steps=0 goes to DONE.
  - Otherwise clear acc[0..3] and go to FEED with phase=0.
  - load_en and start in the same cycle: the load takes effect first; start sees the new values.
- FEED, phase 0..5, one cycle each. Lanes are listed as (Q0i, Q0j, Q1i, Q1j); m lanes follow the same body, 0 where q is 0.
  - P0: (q1, q1, 0, 0).
  - P1: (q1, q3, q2, q2).
  - P2: (q3, q3, q2, q4); acc1 += opr_0.
  - P3: (0, 0, q4, q4); acc1 += opr_0, acc2 += opr_1, acc3 += opd_0.
  - P4: all lanes 0; acc2 += opr_1, acc3 += opr_0, acc4 += opd_1.
  - P5: all lanes 0; acc4 += opr_1.
  - After P5 go to INTEG_REQ with k=0.
  - Accumulation uses the array outputs as sampled at the rising edge that ends the phase. Operands are sign-extended to AW.
- INTEG_REQ:
  - integ_valid=1 with idx=k, q[k], q_old[k], acc[k].
  - Request fields are held stable until integ_ready. Do not deassert valid while waiting.
  - Handshake on valid&ready, then go to INTEG_WAIT.
- INTEG_WAIT:
  - On integ_rvalid: q_old[k] <= q[k], q[k] <= integ_q_new.
  - If k<3, go to INTEG_REQ with k+1.
  - If k=3, increment step_count; if step_count+1 == num_steps go to DONE, else clear accs and go to FEED P0.
  - integ_rvalid outside INTEG_WAIT is ignored.
- All 4 bodies integrate after the FEED of a step completes, so every acceleration uses positions from the same time level.
- DONE: done=1 for one cycle, then IDLE. step_count holds its value.
- start while busy is ignored. load_en while busy is ignored.
- rst_n asserted mid-run: immediate return to IDLE with all state cleared. Body state is not preserved.
- Lanes are 0 in every state except FEED P0..P3.

Decomposition:
- Package systolic_nbody_pkg: state enum, NUM_BODIES=4, FEED_PHASES=6, and the phase lane-select table as constant arrays of body indices, with 0 meaning the lane is zero.
- One natural sub-module: systolic_2x2_accum, holding the 4 AW accumulators, clear, and phase-indexed add enables.
- The FSM stays in the top module.

Test Plan:
- Reset/idle: hold rst_n low, then release → all outputs 0, busy=0; start with num_steps=0 → done pulse after 1 cycle, step_count=0.
- Lane sequence: load q=-2,-1,1,2, m=1,1,1,1; start num_steps=1 → P0..P5 lanes exactly match the FEED table, e.g. P2 = (1, 1, -1, 2).
- Accumulation: stub array drives constant opr_0=3, opr_1=5, opd_0=7, opd_1=11 → integ_a = 6, 10, 10, 16 for bodies 0..3.
- Integration handshake: integ_ready delayed 3 cycles and rvalid 2 cycles later → request fields stable throughout. Stub returns q_new=q+1 → after the step q=-1,0,2,3 and q_old=-2,-1,1,2.
- Multi-step: num_steps=3 with the same stub → step_count reaches 3, final q=1,2,4,5, a single done pulse, and busy high for the whole run.
- Reset mid-run: assert rst_n low during INTEG_WAIT of step 2 → IDLE, q registers 0, step_count 0, a later start runs cleanly.
